// File: rtl/cache_arbiter.sv
// Round-robin arbiter that funnels N_REQ requesters onto a single cache port.
// Optional BUSY watchdog is compiled in with `define CACHE_ARB_TIMEOUT_EN.
module cache_arbiter #(
   parameter int unsigned N_REQ          = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rstn_i,
   input  logic [N_REQ-1:0]         rq_read_i,
   input  logic [N_REQ-1:0]         rq_write_i,
   input  logic [4*N_REQ-1:0]       rq_we_i,
   input  logic [32*N_REQ-1:0]      rq_addr_i,
   input  logic [32*N_REQ-1:0]      rq_data_i,
   output logic [31:0]              rq_data_o,
   output logic [N_REQ-1:0]         rq_valid_o,
   output logic                     c_read_o,
   output logic                     c_write_o,
   output logic [3:0]               c_we_o,
   output logic [31:0]              c_addr_o,
   output logic [31:0]              c_data_o,
   input  logic [31:0]              c_data_i,
   input  logic                     c_valid_i,
   output logic [$clog2(N_REQ)-1:0] grant_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int unsigned IW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("cache_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic {IDLE, BUSY} state_e;

   state_e          state_q;
   logic [IW-1:0]   owner_q;
   logic [IW-1:0]   last_q;

   logic [N_REQ-1:0] active;
   logic [3:0]       we_a   [N_REQ];
   logic [31:0]      addr_a [N_REQ];
   logic [31:0]      wdat_a [N_REQ];
   logic [IW-1:0]    winner;
   logic [IW-1:0]    sel;
   logic             found;
   logic             fwd;
   logic             timeout;
   int unsigned      rr;

   assign active = rq_read_i | rq_write_i;

   always_comb begin : unpack
      for (int unsigned k = 0; k < N_REQ; k++) begin
         we_a[k]   = rq_we_i[4*k +: 4];
         addr_a[k] = rq_addr_i[32*k +: 32];
         wdat_a[k] = rq_data_i[32*k +: 32];
      end
   end

   // Winner defaults to last so grant_o holds last when nobody is requesting.
   always_comb begin : arbitrate
      winner = last_q;
      found  = 1'b0;
      rr     = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         rr = (32'(last_q) + i) % N_REQ;
         if (!found && active[IW'(rr)]) begin
            found  = 1'b1;
            winner = IW'(rr);
         end
      end
   end

   assign sel = (state_q == BUSY) ? owner_q : winner;
   assign fwd = (state_q == BUSY) ? active[owner_q] : found;

   always_comb begin : forward
      c_write_o  = fwd & rq_write_i[sel];
      c_read_o   = fwd & rq_read_i[sel] & ~rq_write_i[sel];
      c_we_o     = fwd ? we_a[sel]   : '0;
      c_addr_o   = fwd ? addr_a[sel] : '0;
      c_data_o   = fwd ? wdat_a[sel] : '0;
      rq_valid_o = '0;
      if (fwd && c_valid_i) begin
         rq_valid_o[sel] = 1'b1;
      end
   end

   assign rq_data_o = c_data_i;
   assign grant_o   = sel;
   assign busy_o    = (state_q == BUSY);

`ifdef CACHE_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;

   // Counter sits at zero in IDLE, so the first BUSY cycle sees 0.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else if (state_q == IDLE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign timeout = (state_q == BUSY) && fwd && !c_valid_i &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign err_o = timeout;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IW'(N_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  if (c_valid_i) begin
                     last_q <= winner;
                  end else begin
                     state_q <= BUSY;
                     owner_q <= winner;
                  end
               end
            end
            BUSY: begin
               // Completion, abort and watchdog expiry all release the owner.
               if (!fwd || c_valid_i || timeout) begin
                  state_q <= IDLE;
                  last_q  <= owner_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter (N_REQ=2) against a cycle-level model.
module tb_cache_arbiter;

   localparam int N  = 2;
   localparam int TO = 16;
`ifdef CACHE_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [1:0]  rd, wr;
   logic [7:0]  we;
   logic [63:0] addr, wdata;
   logic [31:0] cdata;
   logic        cvalid;

   logic [31:0] rq_data;
   logic [1:0]  rq_valid;
   logic        c_read, c_write;
   logic [3:0]  c_we;
   logic [31:0] c_addr, c_data;
   logic [0:0]  grant;
   logic        busy, err;

   int checks   = 0;
   int failures = 0;

   bit m_busy;
   int m_owner, m_last, m_cnt;

   cache_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rstn_i(rstn),
      .rq_read_i(rd), .rq_write_i(wr), .rq_we_i(we),
      .rq_addr_i(addr), .rq_data_i(wdata),
      .rq_data_o(rq_data), .rq_valid_o(rq_valid),
      .c_read_o(c_read), .c_write_o(c_write), .c_we_o(c_we),
      .c_addr_o(c_addr), .c_data_o(c_data),
      .c_data_i(cdata), .c_valid_i(cvalid),
      .grant_o(grant), .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input bit r, input bit w, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] d);
      rd[k]          = r;
      wr[k]          = w;
      we[4*k +: 4]   = be;
      addr[32*k +: 32]  = a;
      wdata[32*k +: 32] = d;
   endtask

   // One clock cycle: check outputs against the model, then advance the model.
   task automatic cyc();
      int sel;
      bit found, fwd, to;
      #2;
      sel   = m_last;
      found = 1'b0;
      if (!m_busy) begin
         for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_last + i) % N;
            if (!found && (rd[k] | wr[k])) begin
               found = 1'b1;
               sel   = k;
            end
         end
         fwd = found;
      end else begin
         sel = m_owner;
         fwd = rd[m_owner] | wr[m_owner];
      end
      to = TO_EN && m_busy && fwd && !cvalid && (m_cnt == TO - 1);

      chk("c_write",  64'(c_write),  64'(fwd && wr[sel]));
      chk("c_read",   64'(c_read),   64'(fwd && rd[sel] && !wr[sel]));
      chk("c_we",     64'(c_we),     fwd ? 64'(we[4*sel +: 4]) : 64'd0);
      chk("c_addr",   64'(c_addr),   fwd ? 64'(addr[32*sel +: 32]) : 64'd0);
      chk("c_data",   64'(c_data),   fwd ? 64'(wdata[32*sel +: 32]) : 64'd0);
      chk("grant",    64'(grant),    64'(sel));
      chk("rq_valid", 64'(rq_valid), (fwd && cvalid) ? (64'd1 << sel) : 64'd0);
      chk("rq_data",  64'(rq_data),  64'(cdata));
      chk("busy",     64'(busy),     64'(m_busy));
      chk("err",      64'(err),      64'(to));

      @(posedge clk);
      if (!m_busy) begin
         if (fwd) begin
            if (cvalid) m_last = sel;
            else begin
               m_busy  = 1'b1;
               m_owner = sel;
               m_cnt   = 0;
            end
         end
      end else if (!fwd || cvalid || to) begin
         m_busy = 1'b0;
         m_last = m_owner;
      end else begin
         m_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_err",   64'(err),   64'd0);
      chk("rst_grant", 64'(grant), (rd[0] | wr[0]) ? 64'd0 : 64'd1);
      m_busy = 1'b0;
      m_last = N - 1;
      m_cnt  = 0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      int order [4];
      order = '{0, 1, 0, 1};
      rd = '0; wr = '0; we = '0; addr = '0; wdata = '0;
      cdata = 32'h0; cvalid = 1'b0; rstn = 1'b1;
      m_busy = 1'b0; m_last = N - 1; m_owner = 0; m_cnt = 0;
      @(negedge clk);
      do_reset();
      chk("rst_c_read", 64'(c_read), 64'd0);

      // Hit in the arbitration cycle
      set_req(0, 1, 0, 4'h0, 32'h100, 32'h0);
      cdata = 32'hA5A5_0001; cvalid = 1'b1;
      cyc();
      chk("hit_busy", 64'(busy), 64'd0);
      cvalid = 1'b0; rd = '0;

      // Alternating BUSY transfers from two readers
      do_reset();
      set_req(0, 1, 0, 4'h0, 32'h200, 32'h0);
      set_req(1, 1, 0, 4'h0, 32'h300, 32'h0);
      for (int t = 0; t < 4; t++) begin
         cdata = 32'h1000 + 32'(t);
         cyc();
         chk("grant_order", 64'(grant), 64'(order[t]));
         repeat (9) cyc();
         cvalid = 1'b1;
         cyc();
         cvalid = 1'b0;
         chk("idle_gap", 64'(busy), 64'd0);
      end
      rd = '0;
      cyc();

      // Write from req1 waits behind req0
      set_req(0, 1, 0, 4'h0, 32'h400, 32'h0);
      cyc();
      set_req(1, 0, 1, 4'b0011, 32'h500, 32'hDEAD_BEEF);
      repeat (4) cyc();
      #1;
      chk("blocked_addr", 64'(c_addr), 64'h400);
      cvalid = 1'b1;
      cyc();
      cvalid = 1'b0;
      rd[0] = 1'b0;
      #1;
      chk("wr_c_write", 64'(c_write), 64'd1);
      chk("wr_c_we",    64'(c_we),    64'h3);
      chk("wr_c_data",  64'(c_data),  64'hDEAD_BEEF);
      cyc();
      cvalid = 1'b1;
      cyc();
      cvalid = 1'b0; wr = '0;

      // Owner abort in BUSY cycle 3
      set_req(0, 1, 0, 4'h0, 32'h600, 32'h0);
      set_req(1, 1, 0, 4'h0, 32'h700, 32'h0);
      cyc();
      cyc();
      cyc();
      rd[0] = 1'b0;
      #1;
      chk("abort_read",  64'(c_read),   64'd0);
      chk("abort_addr",  64'(c_addr),   64'd0);
      chk("abort_valid", 64'(rq_valid), 64'd0);
      cyc();
      rd[0] = 1'b1;
      #1;
      chk("abort_next_grant", 64'(grant), 64'd1);
      cvalid = 1'b1;
      cyc();
      cvalid = 1'b0; rd = '0;
      cyc();

      // Cache never answers
      set_req(0, 1, 0, 4'h0, 32'h800, 32'h0);
      cyc();
`ifdef CACHE_ARB_TIMEOUT_EN
      repeat (15) cyc();
      #1;
      chk("to_err",  64'(err),  64'd1);
      chk("to_busy", 64'(busy), 64'd1);
      cyc();
      chk("to_idle", 64'(busy), 64'd0);
      cyc();
`else
      repeat (20) cyc();
      chk("noto_busy", 64'(busy), 64'd1);
      chk("noto_err",  64'(err),  64'd0);
`endif

      // Reset in the middle of a BUSY transfer
      rd = 2'b11;
      #2;
      chk("pre_rst_busy", 64'(busy), 64'd1);
      do_reset();
      cyc();
      chk("post_rst_grant", 64'(grant), 64'd0);
      cvalid = 1'b1;
      cyc();
      cvalid = 1'b0; rd = '0;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rd     = 2'($urandom_range(0, 3));
         wr     = ($urandom % 3 == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         we     = 8'($urandom);
         addr   = {32'($urandom), 32'($urandom)};
         wdata  = {32'($urandom), 32'($urandom)};
         cdata  = 32'($urandom);
         cvalid = ($urandom % 4 == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The parameter list SHALL be: N_REQ, 2, number of requester ports (2..8).
REQ-002 The parameter list SHALL include: TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only under CACHE_ARB_TIMEOUT_EN).
REQ-003 The port list SHALL be, in this order:
- clk  input  1  clock, all state updates on the rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- rq_read_i  input  N_REQ  per-requester read request.
- rq_write_i  input  N_REQ  per-requester write request.
- rq_we_i  input  4*N_REQ  per-requester byte-enable; slice k is [4k+3:4k].
- rq_addr_i  input  32*N_REQ  per-requester address.
- rq_data_i  input  32*N_REQ  per-requester write data.
- rq_data_o  output  32  read data, shared by all requesters.
- rq_valid_o  output  N_REQ  one-hot completion strobe.
- c_read_o  output  1  cache read request.
- c_write_o  output  1  cache write request.
- c_we_o  output  4  cache byte-enable.
- c_addr_o  output  32  cache address.
- c_data_o  output  32  cache write data.
- c_data_i  input  32  cache read data.
- c_valid_i  input  1  cache completion, valid in the same cycle as the request on a hit.
- grant_o  output  $clog2(N_REQ)  index of the current owner.
- busy_o  output  1  high in BUSY.
- err_o  output  1  one-cycle watchdog pulse.

Function
REQ-004 The FSM SHALL have two states, IDLE and BUSY.
REQ-005 A requester k SHALL be active when rq_read_i[k] or rq_write_i[k] is high.
REQ-006 In IDLE, the winner SHALL be the first active requester found round-robin, starting at (last+1) mod N_REQ, where last is the most recent completed or aborted owner.
REQ-007 In IDLE, the winner's fields SHALL be forwarded combinationally to c_* in the same cycle (zero arbitration latency), and grant_o SHALL equal the winner.
REQ-008 If c_valid_i is high in that IDLE cycle: rq_valid_o[winner]=1, last<=winner, FSM stays IDLE.
REQ-009 If c_valid_i is low in that IDLE cycle, the FSM SHALL register the owner and go to BUSY.
REQ-010 In BUSY, only the locked owner SHALL be forwarded; other requests are ignored, not queued.
REQ-011 In BUSY, when c_valid_i=1: rq_valid_o[owner]=1 in the same cycle, last<=owner, next state IDLE.
REQ-012 A new transaction SHALL NOT be accepted in the cycle a BUSY transaction completes; back-to-back BUSY transfers therefore have one IDLE cycle between them.
REQ-013 If the owner deasserts both read and write in BUSY (abort), all c_* SHALL be driven 0, rq_valid_o SHALL stay 0, last<=owner, next state IDLE.
REQ-014 If a requester asserts both read and write, c_write_o SHALL be 1 and c_read_o SHALL be 0.
REQ-015 rq_data_o SHALL equal c_data_i at all times; requesters qualify it with rq_valid_o.
REQ-016 When no requester is active in IDLE, all c_* SHALL be 0 and grant_o SHALL hold last.
REQ-017 rq_valid_o SHALL be one-hot or zero in every cycle.
REQ-018 Requesters SHALL hold their request fields stable until their rq_valid_o; the arbiter does not latch address or data.

Reset
REQ-019 On rstn_i low, the block SHALL immediately set: FSM=IDLE, last=N_REQ-1 (requester 0 wins first), busy_o=0, err_o=0, watchdog=0.
REQ-020 A reset during BUSY SHALL drop the transaction with no rq_valid_o.
REQ-021 During reset, the combinational outputs SHALL follow REQ-007 from IDLE state.

Configuration
REQ-022 With macro CACHE_ARB_TIMEOUT_EN defined, a counter SHALL run in BUSY (cleared on entry).
REQ-023 With CACHE_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without c_valid_i, the block SHALL pulse err_o for one cycle, set last<=owner, return to IDLE, and raise no rq_valid_o.
REQ-024 Without CACHE_ARB_TIMEOUT_EN, there SHALL be no counter, err_o SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-025 The bench SHALL cover these scenarios (N_REQ=2):
- Reset; req0 read addr 0x100 with c_valid_i=1 same cycle -> rq_valid_o=01, rq_data_o=c_data_i, busy_o stays 0.
- req0 and req1 both read, c_valid_i after 10 cycles each -> grant order 0,1,0,1; each transfer followed by one IDLE cycle; rq_valid_o never 11.
- req1 write we=0011 data 0xDEADBEEF during req0 BUSY -> req1 not forwarded until req0 completes; then c_write_o=1, c_we_o=0011, c_data_o=0xDEADBEEF.
- Owner drops request in BUSY cycle 3 -> c_* all 0 next cycle, no rq_valid_o, the other requester wins next.
- CACHE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, c_valid_i never high -> err_o pulse in the 16th BUSY cycle, FSM returns to IDLE; without the macro, busy_o stays 1 and err_o stays 0.
- rstn_i low mid-BUSY -> busy_o=0 immediately, requester 0 wins first after release.
